// File: rtl/axi_burst_master.sv
// axi_burst_master: AXI4-full master that runs one write or read burst of
// 1..BUF_DEPTH beats per command, sourcing or sinking beats in a local buffer.
// Optional feature macro: AXI_BURST_MASTER_WRAP_EN (makes WRAP bursts legal).
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   cmd_*                   command handshake (write/read, beat addr, len, burst)
//   done, err               one-cycle completion pulse and its status code
//   buf_we/addr/wdata/rdata host access to the beat buffer
//   aw*, w*, b*, ar*, r*    AXI4 master channels (side-band fields tied to 0)
module axi_burst_master #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 256,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                                     aclk,
    input  logic                                     areset,
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic                                     cmd_write,
    input  logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] cmd_addr,
    input  logic [8:0]                               cmd_len,
    input  logic [1:0]                               cmd_burst,
    output logic                                     done,
    output logic [1:0]                               err,
    input  logic                                     buf_we,
    input  logic [$clog2(BUF_DEPTH)-1:0]             buf_addr,
    input  logic [DATA_WIDTH-1:0]                    buf_wdata,
    output logic [DATA_WIDTH-1:0]                    buf_rdata,
    output logic [ID_WIDTH-1:0]                      awid,
    output logic [ADDR_WIDTH-1:0]                    awaddr,
    output logic [7:0]                               awlen,
    output logic [2:0]                               awsize,
    output logic [1:0]                               awburst,
    output logic                                     awlock,
    output logic [3:0]                               awcache,
    output logic [2:0]                               awprot,
    output logic [3:0]                               awqos,
    output logic [3:0]                               awregion,
    output logic                                     awvalid,
    input  logic                                     awready,
    output logic [DATA_WIDTH-1:0]                    wdata,
    output logic [DATA_WIDTH/8-1:0]                  wstrb,
    output logic                                     wlast,
    output logic                                     wvalid,
    input  logic                                     wready,
    input  logic [ID_WIDTH-1:0]                      bid,
    input  logic [1:0]                               bresp,
    input  logic                                     bvalid,
    output logic                                     bready,
    output logic [ID_WIDTH-1:0]                      arid,
    output logic [ADDR_WIDTH-1:0]                    araddr,
    output logic [7:0]                               arlen,
    output logic [2:0]                               arsize,
    output logic [1:0]                               arburst,
    output logic                                     arlock,
    output logic [3:0]                               arcache,
    output logic [2:0]                               arprot,
    output logic [3:0]                               arqos,
    output logic [3:0]                               arregion,
    output logic                                     arvalid,
    input  logic                                     arready,
    input  logic [ID_WIDTH-1:0]                      rid,
    input  logic [DATA_WIDTH-1:0]                    rdata,
    input  logic [1:0]                               rresp,
    input  logic                                     rlast,
    input  logic                                     rvalid,
    output logic                                     rready
);
    localparam int unsigned BB = $clog2(DATA_WIDTH/8);
    localparam int unsigned BW = $clog2(BUF_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [8:0]            r_len, r_beat, w_beat_nxt;
    logic [TW-1:0]         r_tmo, w_tmo_nxt;
    logic                  r_rflag, w_rflag_nxt;
    logic [1:0]            w_err_nxt;
    logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic w_accept, w_illegal, w_wrap_bad, w_last_beat, w_tmo_hit, w_beat_done, w_rbad;

    // Registered outputs and their next values
    logic r_cmd_ready, r_done, r_awvalid, r_wvalid, r_wlast, r_bready, r_arvalid, r_rready;
    logic [1:0] r_err;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
    logic [7:0] r_awlen, r_arlen;
    logic [1:0] r_awburst, r_arburst;
    logic w_cmd_ready_d, w_done_d, w_awvalid_d, w_wvalid_d, w_wlast_d, w_bready_d, w_arvalid_d, w_rready_d;
    logic [1:0] w_err_d;
    logic [DATA_WIDTH-1:0] w_wdata_d;

`ifdef AXI_BURST_MASTER_WRAP_EN
    assign w_wrap_bad = (cmd_burst == 2'b10) && !((cmd_len == 9'd2) || (cmd_len == 9'd4) ||
                                                  (cmd_len == 9'd8) || (cmd_len == 9'd16));
`else
    assign w_wrap_bad = (cmd_burst == 2'b10);
`endif

    assign w_illegal   = (cmd_len == 9'd0) || (cmd_len > 9'(BUF_DEPTH)) || (cmd_burst == 2'b11) ||
                         ((cmd_burst == 2'b00) && (cmd_len > 9'd16)) || w_wrap_bad;
    assign w_accept    = (r_state == S_IDLE) && r_cmd_ready && cmd_valid;
    assign w_last_beat = (r_beat == (r_len - 9'd1));
    assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));
    // rlast must coincide exactly with the final beat
    assign w_rbad      = (rresp != 2'b00) || (rid != '0) || (rlast != w_last_beat);

    // State register and command/beat bookkeeping
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_beat  <= '0;
            r_tmo   <= '0;
            r_rflag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_tmo   <= w_tmo_nxt;
            r_rflag <= w_rflag_nxt;
            if (w_accept) r_len <= cmd_len;
        end
    end

    // Next-state logic; the timeout counter restarts on state change or beat
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_rflag_nxt = r_rflag;
        w_err_nxt   = 2'b00;
        w_beat_done = 1'b0;
        w_tmo_nxt   = r_tmo + TW'(1);
        case (r_state)
            S_IDLE: begin
                w_beat_nxt  = '0;
                w_rflag_nxt = 1'b0;
                if (w_accept) begin
                    if (w_illegal) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 2'b11;
                    end else begin
                        w_state_nxt = cmd_write ? S_AW : S_AR;
                    end
                end
            end
            S_AW, S_AR: begin
                if ((r_state == S_AW) ? awready : arready)
                    w_state_nxt = (r_state == S_AW) ? S_W : S_R;
                else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 2'b10;
                end
            end
            S_W: begin
                if (wready) begin
                    w_beat_done = 1'b1;
                    if (w_last_beat) w_state_nxt = S_B;
                    else             w_beat_nxt  = r_beat + 9'd1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 2'b10;
                end
            end
            S_B: begin
                if (bvalid) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = ((bresp != 2'b00) || (bid != '0)) ? 2'b01 : 2'b00;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 2'b10;
                end
            end
            S_R: begin
                if (rvalid) begin
                    w_beat_done = 1'b1;
                    w_rflag_nxt = r_rflag | w_rbad;
                    if (w_last_beat) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = (r_rflag | w_rbad) ? 2'b01 : 2'b00;
                    end else begin
                        w_beat_nxt = r_beat + 9'd1;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 2'b10;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if ((w_state_nxt != r_state) || w_beat_done) w_tmo_nxt = '0;
    end

    // Output decode from the next state, so registered outputs track the state
    always_comb begin
        w_cmd_ready_d = (w_state_nxt == S_IDLE);
        w_awvalid_d   = (w_state_nxt == S_AW);
        w_wvalid_d    = (w_state_nxt == S_W);
        w_wlast_d     = (w_state_nxt == S_W) && (w_beat_nxt == (r_len - 9'd1));
        w_wdata_d     = (w_state_nxt == S_W) ? r_buf[w_beat_nxt[BW-1:0]] : '0;
        w_bready_d    = (w_state_nxt == S_B);
        w_arvalid_d   = (w_state_nxt == S_AR);
        w_rready_d    = (w_state_nxt == S_R);
        w_done_d      = (w_state_nxt == S_DONE);
        w_err_d       = (w_state_nxt == S_DONE) ? w_err_nxt : 2'b00;
    end

    // Output registers; address fields load on a legal accept
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cmd_ready <= 1'b0; r_done   <= 1'b0; r_err    <= 2'b00;
            r_awvalid   <= 1'b0; r_wvalid <= 1'b0; r_wlast  <= 1'b0; r_wdata <= '0;
            r_bready    <= 1'b0; r_arvalid <= 1'b0; r_rready <= 1'b0;
            r_awaddr    <= '0; r_awlen <= '0; r_awburst <= '0;
            r_araddr    <= '0; r_arlen <= '0; r_arburst <= '0;
        end else begin
            r_cmd_ready <= w_cmd_ready_d; r_done   <= w_done_d;   r_err    <= w_err_d;
            r_awvalid   <= w_awvalid_d;   r_wvalid <= w_wvalid_d; r_wlast  <= w_wlast_d;
            r_wdata     <= w_wdata_d;     r_bready <= w_bready_d;
            r_arvalid   <= w_arvalid_d;   r_rready <= w_rready_d;
            if (w_accept && !w_illegal && cmd_write) begin
                r_awaddr  <= ADDR_WIDTH'({cmd_addr, {BB{1'b0}}});
                r_awlen   <= 8'(cmd_len - 9'd1);
                r_awburst <= cmd_burst;
            end
            if (w_accept && !w_illegal && !cmd_write) begin
                r_araddr  <= ADDR_WIDTH'({cmd_addr, {BB{1'b0}}});
                r_arlen   <= 8'(cmd_len - 9'd1);
                r_arburst <= cmd_burst;
            end
        end
    end

    // Beat buffer: read beats land here; host writes only while idle
    always_ff @(posedge aclk) begin
        if ((r_state == S_R) && rvalid)
            r_buf[r_beat[BW-1:0]] <= rdata;
        else if ((r_state == S_IDLE) && buf_we)
            r_buf[buf_addr] <= buf_wdata;
    end

    assign buf_rdata = r_buf[buf_addr];

    assign cmd_ready = r_cmd_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign awid      = '0;
    assign awaddr    = r_awaddr;
    assign awlen     = r_awlen;
    assign awsize    = 3'(BB);
    assign awburst   = r_awburst;
    assign awlock    = 1'b0;
    assign awcache   = 4'd0;
    assign awprot    = 3'd0;
    assign awqos     = 4'd0;
    assign awregion  = 4'd0;
    assign awvalid   = r_awvalid;
    assign wdata     = r_wdata;
    assign wstrb     = {(DATA_WIDTH/8){r_wvalid}};
    assign wlast     = r_wlast;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;
    assign arid      = '0;
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = 3'(BB);
    assign arburst   = r_arburst;
    assign arlock    = 1'b0;
    assign arcache   = 4'd0;
    assign arprot    = 3'd0;
    assign arqos     = 4'd0;
    assign arregion  = 4'd0;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;
endmodule
